// File: rtl/serial_add_arbiter.sv
// Two-client round-robin front end for a single bit-serial adder.
// The winner's operands are shifted through a half-adder pair LSB-first over WIDTH cycles.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             ptr_reg;

  logic             ha1_s, ha1_c, ha2_c;
  logic             bit_sum, carry_next;
  logic [WIDTH-1:0] sum_sh_next;
  logic             pick1;

  always_comb begin
    ha1_s       = a_sh_reg[0] ^ b_sh_reg[0];
    ha1_c       = a_sh_reg[0] & b_sh_reg[0];
    bit_sum     = ha1_s ^ carry_reg;
    ha2_c       = ha1_s & carry_reg;
    carry_next  = ha1_c | ha2_c;
    // New bits enter at the MSB so the first (LSB) result ends up in bit 0.
    sum_sh_next = sum_sh_reg >> 1;
    sum_sh_next[WIDTH-1] = bit_sum;
    // On a tie, the requester not served last wins.
    pick1       = req1 & (~req0 | ~ptr_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
      ptr_reg    <= 1'b1;
      gnt        <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 | req1) begin
            a_sh_reg  <= pick1 ? a1 : a0;
            b_sh_reg  <= pick1 ? b1 : b0;
            carry_reg <= 1'b0;
            count_reg <= '0;
            gnt       <= pick1 ? 2'b10 : 2'b01;
            ptr_reg   <= pick1;
            busy      <= 1'b1;
            state_reg <= ADD;
          end
        end
        ADD: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= carry_next;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            count_reg <= '0;
            sum       <= sum_sh_next;
            cout      <= carry_next;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          gnt       <= 2'b00;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: an 8-bit instance for arbitration and arithmetic,
// a 1-bit instance for the minimum-width corner.
module tb_serial_add_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] gnt;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       w_req0;
  logic [0:0] w_a0, w_b0, w_a1, w_b1, w_sum;
  logic       w_req1;
  logic [1:0] w_gnt;
  logic       w_busy, w_done, w_cout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  serial_add_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_arbiter #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0(w_req0), .a0(w_a0), .b0(w_b0),
    .req1(w_req1), .a1(w_a1), .b1(w_b1),
    .gnt(w_gnt), .busy(w_busy), .done(w_done), .sum(w_sum), .cout(w_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the always-true invariants of both instances.
  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    chk("gnt8_not_both", {31'b0, gnt === 2'b11}, 32'd0);
    chk("done8_outside_op", {31'b0, done === 1'b1 && gnt === 2'b00}, 32'd0);
    chk("gnt1_not_both", {31'b0, w_gnt === 2'b11}, 32'd0);
    chk("done1_outside_op", {31'b0, w_done === 1'b1 && w_gnt === 2'b00}, 32'd0);
  endtask

  // Cycle 0 is the idle cycle whose closing edge grants; done is due in cycle 9.
  task automatic op8(input bit sel, input logic [7:0] a, input logic [7:0] b, input string tag);
    int cyc;
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b};
    if (sel) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    done_cnt = 0;
    tick();
    cyc = 1;
    chk({tag, "_gnt"}, {30'b0, gnt}, sel ? 32'd2 : 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 32'd9);
    chk({tag, "_result"}, {23'b0, cout, sum}, {23'b0, exp});
    if (sel) req1 = 1'b0; else req0 = 1'b0;
    tick();
    chk({tag, "_idle_gnt"}, {30'b0, gnt}, 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done_once"}, done_cnt, 32'd1);
    chk({tag, "_sum_hold"}, {23'b0, cout, sum}, {23'b0, exp});
  endtask

  initial begin
    int cyc;
    logic [8:0] exp0, exp1;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    w_req0 = 1'b0; w_req1 = 1'b0;
    w_a0 = '0; w_b0 = '0; w_a1 = '0; w_b1 = '0;
    tick();
    tick();
    chk("rst_outputs8", {21'b0, gnt, busy, done, cout, sum}, 32'd0);
    chk("rst_outputs1", {26'b0, w_gnt, w_busy, w_done, w_cout, w_sum}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1 / T2
    op8(1'b0, 8'h0F, 8'h01, "t1");
    op8(1'b1, 8'hFF, 8'h01, "t2a");
    op8(1'b1, 8'hAA, 8'h55, "t2b");

    // T3: both requesters held from reset; grants must alternate starting with 0
    rst_n = 1'b0;
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'h4B;
    req1 = 1'b1; a1 = 8'hC8; b1 = 8'h64;
    exp0 = 9'h087;
    exp1 = 9'h12C;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        chk("t3_gap_gnt", {30'b0, gnt}, 32'd0);
      end
      done_cnt = 0;
      tick();
      cyc = 1;
      chk("t3_order", {30'b0, gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      while (done !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("t3_latency", cyc, 32'd9);
      chk("t3_result", {23'b0, cout, sum}, (i % 2 == 0) ? {23'b0, exp0} : {23'b0, exp1});
      chk("t3_done_once", done_cnt, 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("t3_end_gnt", {30'b0, gnt}, 32'd0);

    // T4: operand change and request drop mid-ADD are ignored
    req0 = 1'b1; a0 = 8'h03; b0 = 8'h05;
    done_cnt = 0;
    tick();
    cyc = 1;
    chk("t4_gnt", {30'b0, gnt}, 32'd1);
    tick();
    tick();
    cyc = 3;
    a0 = 8'h7F;
    req0 = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t4_latency", cyc, 32'd9);
    chk("t4_result", {23'b0, cout, sum}, 32'h008);
    tick();
    tick();
    chk("t4_done_once", done_cnt, 32'd1);
    chk("t4_no_regrant", {30'b0, gnt}, 32'd0);

    // T5: reset asserted at ADD count=4 clears outputs at once, no done
    req1 = 1'b1; a1 = 8'h55; b1 = 8'h11;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", {21'b0, gnt, busy, done, cout, sum}, 32'd0);
    req1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_no_done", done_cnt, 32'd0);
    op8(1'b0, 8'h12, 8'h34, "t5_next");

    // T6: WIDTH=1, 1+1
    w_req0 = 1'b1; w_a0 = 1'b1; w_b0 = 1'b1;
    tick();
    chk("t6_gnt", {30'b0, w_gnt}, 32'd1);
    chk("t6_done_early", {31'b0, w_done}, 32'd0);
    tick();
    chk("t6_done", {31'b0, w_done}, 32'd1);
    chk("t6_result", {30'b0, w_cout, w_sum}, 32'd2);
    w_req0 = 1'b0;
    tick();
    chk("t6_done_drop", {31'b0, w_done}, 32'd0);
    chk("t6_idle_gnt", {30'b0, w_gnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
